// File: rtl/arith_loop_kernel.sv
// Counted loop kernel: on start runs BOUND iterations, adding STEP_X to x or STEP_Y to y
// per the selector, with wrap or saturate arithmetic and a sticky overflow flag.
module arith_loop_kernel #(
  parameter int WIDTH  = 15,
  parameter int BOUND  = 1000,
  parameter int STEP_X = 1,
  parameter int STEP_Y = 1,
  parameter int SAT    = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             en_i,
  input  logic             selector_i,
  output logic [WIDTH-1:0] i_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  localparam longint MAXV = (longint'(1) << WIDTH) - 1;

  generate
    if (BOUND < 1 || longint'(BOUND) > MAXV) begin : g_bad_bound
      $error("arith_loop_kernel: BOUND out of range");
    end
    if (STEP_X < 1 || longint'(STEP_X) > MAXV) begin : g_bad_step_x
      $error("arith_loop_kernel: STEP_X out of range");
    end
    if (STEP_Y < 1 || longint'(STEP_Y) > MAXV) begin : g_bad_step_y
      $error("arith_loop_kernel: STEP_Y out of range");
    end
  endgenerate

  localparam logic [WIDTH:0]   STEP_X_W = (WIDTH+1)'(STEP_X);
  localparam logic [WIDTH:0]   STEP_Y_W = (WIDTH+1)'(STEP_Y);
  localparam logic [WIDTH-1:0] LAST_I   = WIDTH'(BOUND - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] i_q, i_d, x_q, x_d, y_q, y_d;
  logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [WIDTH:0]   sum_x, sum_y;

  // Carry-out of the WIDTH+1 bit sum is the overflow indication.
  function automatic logic [WIDTH-1:0] fix_sum(input logic [WIDTH:0] s);
    if (s[WIDTH] && (SAT != 0)) return '1;
    return s[WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    x_d     = x_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    sum_x   = {1'b0, x_q} + STEP_X_W;
    sum_y   = {1'b0, y_q} + STEP_Y_W;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          i_d     = '0;
          x_d     = '0;
          y_d     = '0;
          ovf_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (en_i) begin
          i_d = i_q + WIDTH'(1);
          if (selector_i) begin
            x_d   = fix_sum(sum_x);
            ovf_d = ovf_q | sum_x[WIDTH];
          end else begin
            y_d   = fix_sum(sum_y);
            ovf_d = ovf_q | sum_y[WIDTH];
          end
          if (i_q == LAST_I) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign i_o    = i_q;
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule
